// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with one shared period counter and double-buffered period/duty registers.
// Optional dead-time insertion on the high/low output pairs is built when PWM_DEADTIME_EN is defined.
module pwm_multi_channel #(
    parameter int WIDTH    = 8,
    parameter int NUM_CH   = 4,
    parameter int DT_WIDTH = 4,
    localparam int SEL_W   = $clog2(NUM_CH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                center_mode,
    input  logic                cfg_wr,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [WIDTH-1:0]    cfg_data,
    input  logic [DT_WIDTH-1:0] dead_time,
    output logic [NUM_CH-1:0]   pwm_h,
    output logic [NUM_CH-1:0]   pwm_l,
    output logic                period_done
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0]             cnt;
    logic [WIDTH-1:0]             cnt_n;
    dir_t                         dir;
    dir_t                         dir_n;
    logic                         boundary;
    logic                         commit;

    logic [WIDTH-1:0]             per_sh;
    logic [WIDTH-1:0]             per_act;
    logic [WIDTH-1:0]             per_last;
    logic [NUM_CH-1:0][WIDTH-1:0] duty_sh;
    logic [NUM_CH-1:0][WIDTH-1:0] duty_act;
    logic                         mode_act;

    logic [NUM_CH-1:0]            raw;
    logic [NUM_CH-1:0]            h_q;
    logic [NUM_CH-1:0]            l_q;
    logic                         done_q;
    logic [NUM_CH-1:0]            en_mask;

    // Shadow registers: writes are always accepted, out-of-range selects fall through.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_sh  <= '0;
            duty_sh <= '0;
        end else if (cfg_wr) begin
            if (cfg_sel == SEL_W'(NUM_CH)) begin
                per_sh <= cfg_data;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_sel == SEL_W'(i)) begin
                    duty_sh[i] <= cfg_data;
                end
            end
        end
    end

    assign per_last = per_act - ONE;

    // Counter next-state; every boundary path restarts at 0 counting up.
    always_comb begin
        cnt_n    = cnt;
        dir_n    = dir;
        boundary = 1'b0;
        if (!en) begin
            cnt_n = '0;
            dir_n = DIR_UP;
        end else if (!mode_act) begin
            dir_n = DIR_UP;
            if (cnt == per_act) begin
                boundary = 1'b1;
                cnt_n    = '0;
            end else begin
                cnt_n = cnt + ONE;
            end
        end else if (per_act == '0) begin
            boundary = 1'b1;
            cnt_n    = '0;
            dir_n    = DIR_UP;
        end else begin
            case (dir)
                DIR_UP: begin
                    if (cnt == per_last) begin
                        dir_n = DIR_DOWN;
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end
                DIR_DOWN: begin
                    if (cnt == '0) begin
                        boundary = 1'b1;
                        dir_n    = DIR_UP;
                    end else begin
                        cnt_n = cnt - ONE;
                    end
                end
                default: begin
                    cnt_n = '0;
                    dir_n = DIR_UP;
                end
            endcase
        end
    end

    assign commit = ~en | boundary;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            dir      <= DIR_UP;
            per_act  <= '0;
            duty_act <= '0;
            mode_act <= 1'b0;
        end else begin
            cnt <= cnt_n;
            dir <= dir_n;
            if (commit) begin
                per_act  <= per_sh;
                duty_act <= duty_sh;
                mode_act <= center_mode;
            end
        end
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            raw[i] = (cnt < duty_act[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q    <= '0;
            l_q    <= '0;
            done_q <= 1'b0;
        end else begin
            h_q    <= en ? raw : '0;
            l_q    <= en ? ~raw : '0;
            done_q <= en & boundary;
        end
    end

    // Outputs are forced low in any cycle the block is not enabled.
    assign en_mask     = {NUM_CH{en}};
    assign period_done = done_q & en;

`ifdef PWM_DEADTIME_EN
    localparam logic [DT_WIDTH-1:0] DT_MAX = '1;

    // Count how many cycles each registered phase has already been high.
    logic [NUM_CH-1:0][DT_WIDTH-1:0] h_run;
    logic [NUM_CH-1:0][DT_WIDTH-1:0] l_run;
    logic [NUM_CH-1:0]               h_ok;
    logic [NUM_CH-1:0]               l_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_run <= '0;
            l_run <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (h_q[i]) begin
                    h_run[i] <= (h_run[i] == DT_MAX) ? h_run[i] : h_run[i] + DT_WIDTH'(1);
                end else begin
                    h_run[i] <= '0;
                end
                if (l_q[i]) begin
                    l_run[i] <= (l_run[i] == DT_MAX) ? l_run[i] : l_run[i] + DT_WIDTH'(1);
                end else begin
                    l_run[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        h_ok = '0;
        l_ok = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            h_ok[i] = (h_run[i] >= dead_time);
            l_ok[i] = (l_run[i] >= dead_time);
        end
    end

    assign pwm_h = h_q & h_ok & en_mask;
    assign pwm_l = l_q & l_ok & en_mask;
`else
    logic unused_dead_time;
    assign unused_dead_time = ^dead_time;

    assign pwm_h = h_q & en_mask;
    assign pwm_l = l_q & en_mask;
`endif

endmodule
